// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - round-robin arbiter and APB4 master sequencer for NUM_REQ requesters
module apb_master_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_slverr,
    output logic                           wr,
    output logic                           sel,
    output logic                           enable,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH/8-1:0]        strb,
    input  logic [DATA_WIDTH-1:0]          rdata,
    input  logic                           ready,
    input  logic                           slverr
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   winner;
    logic            found;
    int              rr_idx;
    logic [TW-1:0]   tcnt;
    logic            access_done;
    logic            timed_out;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [SW-1:0]         strb_arr  [NUM_REQ];

    // Split the flat request buses into per-requester fields
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            strb_arr[i]  = req_strb[i*SW +: SW];
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[IW'(rr_idx)]) begin
                found  = 1'b1;
                winner = IW'(rr_idx);
            end
        end
    end

    // Next-state logic and APB phase outputs
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        sel         = 1'b0;
        enable      = 1'b0;
        access_done = 1'b0;
        timed_out   = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = S_SETUP;
                end
            end
            S_SETUP: begin
                sel       = 1'b1;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                sel    = 1'b1;
                enable = 1'b1;
                if (ready) begin
                    access_done = 1'b1;
                end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th ACCESS cycle without ready
                    timed_out = 1'b1;
                end
                if (access_done || timed_out) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and arbitration history
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            cur        <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && found) begin
                last_grant <= winner;
                cur        <= winner;
            end
        end
    end

    // Capture the granted command; held stable through SETUP and ACCESS
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            strb  <= '0;
        end else if (state == S_IDLE && found) begin
            wr    <= req_wr[winner];
            addr  <= addr_arr[winner];
            wdata <= wdata_arr[winner];
            strb  <= req_wr[winner] ? strb_arr[winner] : '0;
        end
    end

    // Count ACCESS cycles spent waiting for ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (state == S_IDLE && found) begin
            tcnt <= '0;
        end else if (state == S_ACCESS && !ready && !timed_out) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Response pulse to the granted requester; data and error hold until the next response
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (access_done || timed_out) begin
                rsp_valid[cur] <= 1'b1;
                rsp_rdata      <= (access_done && !wr) ? rdata : '0;
                rsp_slverr     <= access_done ? slverr : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - self-checking bench for apb_master_arb
module tb_apb_master_arb;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       req_wr;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_wdata;
    logic [NR*SW-1:0]    req_strb;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_slverr;
    logic                wr, sel, enable;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       wdata;
    logic [SW-1:0]       strb;
    logic [DW-1:0]       rdata;
    logic                ready;
    logic                slverr;

    always #5 clk = ~clk;

    apb_master_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .wr(wr), .sel(sel), .enable(enable), .addr(addr), .wdata(wdata), .strb(strb),
        .rdata(rdata), .ready(ready), .slverr(slverr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requester commands and per-command slave behaviour
    logic [NR-1:0] pend;
    logic          c_wr    [NR];
    logic [AW-1:0] c_addr  [NR];
    logic [DW-1:0] c_wdata [NR];
    logic [SW-1:0] c_strb  [NR];
    int            c_wait  [NR];
    bit            c_err   [NR];
    bit            gen_on;
    int            gen_pct, gen_wr_pct, gen_wait_max, gen_err_pct, gen_hang_pct;
    bit            rd_rand;
    logic [DW-1:0] rd_fixed;

    // Transaction-level reference model
    int            m_phase, m_last, m_cur, m_nready, m_wait, m_done;
    bit            m_err;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [NR-1:0] m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;
    logic          m_rsp_slverr;

    // Expected DUT outputs for the current cycle
    logic [NR-1:0] e_req_ready, e_rsp_valid;
    logic          e_sel, e_en, e_wr, e_rsp_slverr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rsp_rdata;
    logic [SW-1:0] e_strb;

    function automatic int rr_pick(int last, logic [NR-1:0] p);
        for (int k = 1; k <= NR; k++) begin
            if (p[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic int oh_idx(logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [111:0] act_vec();
        return {req_ready, sel, enable, wr, addr, wdata, strb, rsp_valid, rsp_rdata, rsp_slverr};
    endfunction

    function automatic logic [111:0] exp_vec();
        return {e_req_ready, e_sel, e_en, e_wr, e_addr, e_wdata, e_strb, e_rsp_valid, e_rsp_rdata, e_rsp_slverr};
    endfunction

    function automatic string vec_str(logic [111:0] v);
        return $sformatf("rdy=%b sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h rspv=%b rdata=%h err=%b",
                         v[111:108], v[107], v[106], v[105], v[104:73], v[72:41], v[40:37],
                         v[36:33], v[32:1], v[0]);
    endfunction

    task automatic new_cmd(input int i);
        c_wr[i]    = ($urandom_range(0, 99) < gen_wr_pct);
        c_addr[i]  = $urandom & 32'hFFFF_FFFC;
        c_wdata[i] = $urandom;
        c_strb[i]  = SW'($urandom_range(0, 15));
        c_wait[i]  = ($urandom_range(0, 99) < gen_hang_pct) ? -1 : int'($urandom_range(0, gen_wait_max));
        c_err[i]   = ($urandom_range(0, 99) < gen_err_pct);
        pend[i]    = 1'b1;
    endtask

    task automatic model_reset();
        pend = '0;
        m_phase = 0; m_last = NR - 1; m_cur = 0; m_nready = 0; m_wait = 0; m_err = 0; m_done = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0;
        m_rsp_valid = '0; m_rsp_rdata = '0; m_rsp_slverr = 1'b0;
        gen_on = 0; gen_pct = 0; gen_wr_pct = 0; gen_wait_max = 0; gen_err_pct = 0; gen_hang_pct = 0;
        rd_rand = 1; rd_fixed = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        ready = 1'b0; slverr = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    // One clock: drive requesters and slave, then at the falling edge derive expectations and advance the model
    task automatic step();
        int w;
        @(posedge clk); #1;
        cyc++;
        if (gen_on) for (int i = 0; i < NR; i++) if (!pend[i] && $urandom_range(0, 99) < gen_pct) new_cmd(i);
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pend[i];
            req_wr[i]               = c_wr[i];
            req_addr[i*AW +: AW]    = c_addr[i];
            req_wdata[i*DW +: DW]   = c_wdata[i];
            req_strb[i*SW +: SW]    = c_strb[i];
        end
        rdata = rd_rand ? DW'($urandom) : rd_fixed;
        if (m_phase == 2) begin
            ready  = (m_wait >= 0) && (m_nready >= m_wait);
            slverr = ready ? m_err : 1'($urandom_range(0, 1));
        end else begin
            ready  = 1'($urandom_range(0, 1));
            slverr = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        e_sel = (m_phase != 0); e_en = (m_phase == 2);
        e_req_ready = '0;
        if (m_phase == 0 && pend != '0) e_req_ready[rr_pick(m_last, pend)] = 1'b1;
        e_wr = m_wr; e_addr = m_addr; e_wdata = m_wdata; e_strb = m_strb;
        e_rsp_valid = m_rsp_valid; e_rsp_rdata = m_rsp_rdata; e_rsp_slverr = m_rsp_slverr;
        m_rsp_valid = '0;
        case (m_phase)
            0: begin
                w = rr_pick(m_last, pend);
                if (w >= 0) begin
                    m_cur = w; m_last = w;
                    m_wr = c_wr[w]; m_addr = c_addr[w]; m_wdata = c_wdata[w];
                    m_strb = c_wr[w] ? c_strb[w] : '0;
                    m_wait = c_wait[w]; m_err = c_err[w];
                    pend[w] = 1'b0;
                    m_phase = 1;
                end
            end
            1: begin
                m_phase = 2; m_nready = 0;
            end
            default: begin
                if (ready) begin
                    m_rsp_valid[m_cur] = 1'b1;
                    m_rsp_rdata = m_wr ? '0 : rdata;
                    m_rsp_slverr = slverr;
                    m_phase = 0; m_done++;
                end else begin
                    m_nready++;
                    if (m_nready == TO) begin
                        m_rsp_valid[m_cur] = 1'b1;
                        m_rsp_rdata = '0;
                        m_rsp_slverr = 1'b1;
                        m_phase = 0; m_done++;
                    end
                end
            end
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL reset_values: got %s want all zero", vec_str(act_vec()));
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_winner: got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_read();
        int n_setup = 0, n_en = 0, n_rsp = 0;
        do_reset();
        rd_rand = 0; rd_fixed = 32'hDEADBEEF;
        c_wr[0] = 0; c_addr[0] = 32'h10; c_wdata[0] = 32'h5555AAAA; c_strb[0] = 4'hF;
        c_wait[0] = 0; c_err[0] = 0; pend[0] = 1;
        for (int n = 0; n < 6; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_read cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (sel && !enable) n_setup++;
            if (enable) n_en++;
            if (rsp_valid != '0) begin
                n_rsp++;
                checks++;
                if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEADBEEF || rsp_slverr !== 1'b0) begin
                    errors++;
                    $display("FAIL single_read_rsp: got v=%b d=%h e=%b want v=0001 d=deadbeef e=0", rsp_valid, rsp_rdata, rsp_slverr);
                end
            end
        end
        checks++;
        if (n_setup !== 1 || n_en !== 1 || n_rsp !== 1) begin
            errors++;
            $display("FAIL single_read_phases: got setup=%0d access=%0d rsp=%0d want 1 1 1", n_setup, n_en, n_rsp);
        end
    endtask

    task automatic test_round_robin();
        int g_idx[$];
        int g_cyc[$];
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        gen_on = 1; gen_pct = 100; gen_wr_pct = 0; gen_wait_max = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL round_robin cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (req_ready != '0) begin
                g_idx.push_back(oh_idx(req_ready));
                g_cyc.push_back(cyc);
            end
            if (sel) begin
                checks++;
                if (strb !== '0) begin
                    errors++;
                    $display("FAIL round_robin_read_strb: got %h want 0", strb);
                end
            end
        end
        checks++;
        if (g_idx.size() < 5) begin
            errors++;
            $display("FAIL round_robin_count: got %0d grants want at least 5", g_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (g_idx[i] != order[i]) begin
                    errors++;
                    $display("FAIL round_robin_order[%0d]: got %0d want %0d", i, g_idx[i], order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (g_cyc[i] - g_cyc[i-1] != 3) begin
                        errors++;
                        $display("FAIL round_robin_spacing[%0d]: got %0d want 3", i, g_cyc[i] - g_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_write_wait();
        int n_en = 0, n_stable = 0, n_rsp = 0;
        do_reset();
        c_wr[1] = 1; c_addr[1] = 32'h20; c_wdata[1] = 32'h12345678; c_strb[1] = 4'b0011;
        c_wait[1] = 5; c_err[1] = 0; pend[1] = 1;
        for (int n = 0; n < 11; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL write_wait cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (enable) begin
                n_en++;
                if (addr === 32'h20 && wdata === 32'h12345678 && strb === 4'b0011 && wr === 1'b1) n_stable++;
            end
            if (rsp_valid != '0) begin
                n_rsp++;
                checks++;
                if (rsp_valid !== 4'b0010 || rsp_rdata !== '0 || rsp_slverr !== 1'b0) begin
                    errors++;
                    $display("FAIL write_wait_rsp: got v=%b d=%h e=%b want v=0010 d=0 e=0", rsp_valid, rsp_rdata, rsp_slverr);
                end
            end
        end
        checks++;
        if (n_en !== 6 || n_stable !== 6 || n_rsp !== 1) begin
            errors++;
            $display("FAIL write_wait_access: got access=%0d stable=%0d rsp=%0d want 6 6 1", n_en, n_stable, n_rsp);
        end
    endtask

    task automatic test_timeout();
        int n_en_first = 0, n_rsp = 0;
        do_reset();
        rd_rand = 0; rd_fixed = 32'hCAFEF00D;
        c_wr[2] = 0; c_addr[2] = 32'h40; c_wdata[2] = '0; c_strb[2] = '0; c_wait[2] = -1; c_err[2] = 0; pend[2] = 1;
        c_wr[3] = 0; c_addr[3] = 32'h44; c_wdata[3] = '0; c_strb[3] = '0; c_wait[3] = 0;  c_err[3] = 0; pend[3] = 1;
        for (int n = 0; n < 16; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (enable && n_rsp == 0) n_en_first++;
            if (rsp_valid != '0) begin
                n_rsp++;
                checks++;
                if (n_rsp == 1 && (rsp_valid !== 4'b0100 || rsp_slverr !== 1'b1 || rsp_rdata !== '0)) begin
                    errors++;
                    $display("FAIL timeout_rsp: got v=%b d=%h e=%b want v=0100 d=0 e=1", rsp_valid, rsp_rdata, rsp_slverr);
                end else if (n_rsp == 2 && (rsp_valid !== 4'b1000 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'hCAFEF00D)) begin
                    errors++;
                    $display("FAIL timeout_next_rsp: got v=%b d=%h e=%b want v=1000 d=cafef00d e=0", rsp_valid, rsp_rdata, rsp_slverr);
                end
            end
        end
        checks++;
        if (n_en_first !== TO || n_rsp !== 2) begin
            errors++;
            $display("FAIL timeout_length: got access=%0d rsp=%0d want %0d 2", n_en_first, n_rsp, TO);
        end
    endtask

    task automatic test_slverr();
        int n_rsp = 0;
        do_reset();
        c_wr[1] = 0; c_addr[1] = 32'h80; c_wdata[1] = '0; c_strb[1] = '0; c_wait[1] = 1; c_err[1] = 1; pend[1] = 1;
        c_wr[2] = 1; c_addr[2] = 32'h84; c_wdata[2] = 32'h0BADF00D; c_strb[2] = 4'hF; c_wait[2] = 0; c_err[2] = 0; pend[2] = 1;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL slverr cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (rsp_valid != '0) begin
                n_rsp++;
                checks++;
                if (n_rsp == 1 && (rsp_valid !== 4'b0010 || rsp_slverr !== 1'b1)) begin
                    errors++;
                    $display("FAIL slverr_port: got v=%b e=%b want v=0010 e=1", rsp_valid, rsp_slverr);
                end else if (n_rsp == 2 && (rsp_valid !== 4'b0100 || rsp_slverr !== 1'b0)) begin
                    errors++;
                    $display("FAIL slverr_clear: got v=%b e=%b want v=0100 e=0", rsp_valid, rsp_slverr);
                end
            end
        end
        checks++;
        if (n_rsp !== 2) begin
            errors++;
            $display("FAIL slverr_count: got %0d responses want 2", n_rsp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_wr[0] = 0; c_addr[0] = 32'hC0; c_wdata[0] = '0; c_strb[0] = '0; c_wait[0] = -1; c_err[0] = 0; pend[0] = 1;
        repeat (3) step();
        checks++;
        if (sel !== 1'b1 || enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_access: got sel=%b en=%b want 1 1", sel, enable);
        end
        @(posedge clk); #1 rst = 1'b0; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sel !== 1'b0 || enable !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid_drop: got sel=%b en=%b rspv=%b want 0 0 0000", sel, enable, rsp_valid);
        end
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            c_wr[i] = 0; c_addr[i] = 32'h100 + 32'(i * 4); c_wait[i] = 0; c_err[i] = 0;
        end
        pend = 4'b1111;
        step();
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid_first: got rdy=%b rspv=%b want 0001 0000", req_ready, rsp_valid);
        end
        for (int n = 0; n < 6; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
        end
    endtask

    task automatic test_random();
        int n_rsp = 0;
        do_reset();
        gen_on = 1; gen_pct = 30; gen_wr_pct = 50; gen_wait_max = 4; gen_err_pct = 12; gen_hang_pct = 3;
        for (int n = 0; n < 700; n++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %s want %s", cyc, vec_str(act_vec()), vec_str(exp_vec()));
            end
            if (rsp_valid != '0) n_rsp++;
        end
        checks++;
        if (n_rsp != m_done - (m_rsp_valid != '0 ? 1 : 0)) begin
            errors++;
            $display("FAIL random_count: got %0d responses want %0d", n_rsp, m_done - (m_rsp_valid != '0 ? 1 : 0));
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        ready = 1'b0; slverr = 1'b0; rdata = '0;
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
